// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared constants and helpers for the key event arbiter
package key_evt_pkg;

    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    localparam int DEFAULT_TICK_DIV = 65536;

    // Width of a key index; never below 1 bit so a 2-key build still has a port.
    function automatic int key_idx_w(input int n_keys);
        return (n_keys <= 2) ? 1 : $clog2(n_keys);
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// rtl/key_debounce_lane.sv - one key lane: synchronizer, tick sampler, debounced level, edges
//
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   inp       : raw asynchronous key level (1 = pressed)
//   tick      : shared sample strobe from the divider
//   level     : debounced key level (registered)
//   rise/fall : combinational, high in the tick cycle whose update changes level
module key_debounce_lane (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_samp;
    logic r_level;
    logic w_agree;

    // Two consecutive ticks must see the same synchronized value.
    assign w_agree = tick && (r_sync2 == r_samp);
    assign rise    = w_agree &&  r_sync2 && !r_level;
    assign fall    = w_agree && !r_sync2 &&  r_level;
    assign level   = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_samp  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= inp;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_samp <= r_sync2;
                if (w_agree) begin
                    r_level <= r_sync2;
                end
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - multi-key debounce with per-key event queueing and round-robin event port
//
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   inp        : raw key levels, one bit per key
//   key_level  : debounced key levels
//   key_press  : one-cycle pulse on each debounced rising edge
//   evt_valid/evt_ready : event port handshake
//   evt_key    : index of the key owning the presented event
//   evt_press  : 1 = press event, 0 = release event
//   evt_ovf    : sticky, set when a new edge merged into an already pending event
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter  int N_KEYS   = 4,
    parameter  int TICK_DIV = DEFAULT_TICK_DIV,
    localparam int KW       = key_idx_w(N_KEYS),
    localparam int CW       = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] inp,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KW-1:0]     evt_key,
    output logic              evt_press,
    output logic              evt_ovf
);

    logic [CW-1:0]     r_cnt;
    logic              w_tick;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_fall;

    logic [N_KEYS-1:0] r_pend_press;
    logic [N_KEYS-1:0] r_pend_rel;
    logic [N_KEYS-1:0] r_key_press;
    logic [KW-1:0]     r_ptr;        // first key examined by the next search
    logic              r_evt_valid;
    logic [KW-1:0]     r_evt_key;
    logic              r_evt_press;
    logic              r_ovf;

    logic [N_KEYS-1:0] w_req;
    logic              w_found;
    logic [KW-1:0]     w_sel;
    logic              w_sel_press;
    logic              w_load;
    logic [N_KEYS-1:0] w_sel_onehot;
    logic [N_KEYS-1:0] w_clr_press;
    logic [N_KEYS-1:0] w_clr_rel;

    assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_debounce_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .inp   (inp[g]),
            .tick  (w_tick),
            .level (key_level[g]),
            .rise  (w_rise[g]),
            .fall  (w_fall[g])
        );
    end

    assign w_req = r_pend_press | r_pend_rel;

    // Round-robin search starting at r_ptr, wrapping mod N_KEYS.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (!w_found && w_req[(int'(r_ptr) + k) % N_KEYS]) begin
                w_found = 1'b1;
                w_sel   = KW'((int'(r_ptr) + k) % N_KEYS);
            end
        end
    end

    assign w_sel_press  = r_pend_press[w_sel];
    assign w_load       = w_found && (!r_evt_valid || evt_ready);
    assign w_sel_onehot = N_KEYS'(1) << w_sel;
    assign w_clr_press  = (w_load &&  w_sel_press) ? w_sel_onehot : '0;
    assign w_clr_rel    = (w_load && !w_sel_press) ? w_sel_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_press <= '0;
            r_pend_rel   <= '0;
            r_key_press  <= '0;
            r_ptr        <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_key    <= '0;
            r_evt_press  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            // A new edge wins over a grant clearing the same bit in this cycle.
            r_pend_press <= (r_pend_press & ~w_clr_press) | w_rise;
            r_pend_rel   <= (r_pend_rel & ~w_clr_rel) | w_fall;
            r_key_press  <= w_rise;

            if ((|(w_rise & r_pend_press & ~w_clr_press)) ||
                (|(w_fall & r_pend_rel & ~w_clr_rel))) begin
                r_ovf <= 1'b1;
            end

            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_key   <= w_sel;
                r_evt_press <= w_sel_press ? EVT_PRESS : EVT_RELEASE;
                r_ptr       <= (w_sel == KW'(N_KEYS - 1)) ? '0 : w_sel + 1'b1;
            end else if (evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign key_press = r_key_press;
    assign evt_valid = r_evt_valid;
    assign evt_key   = r_evt_key;
    assign evt_press = r_evt_press;
    assign evt_ovf   = r_ovf;

endmodule
